// File: rtl/serdesphy_manchester_encoder_pipe.sv
// Manchester encoder for the SerDes TX path: input FIFO feeding a registered biphase output word.
// Optional idle fill on empty output is enabled with SERDESPHY_MENC_IDLE_FILL_EN.
module serdesphy_manchester_encoder_pipe #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                data_valid,
    output logic                data_ready,
    input  logic                polarity,
    input  logic                flush,
    output logic [2*DATA_W-1:0] manchester_data,
    output logic                manchester_valid,
    input  logic                serializer_ready,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                idle_flag
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    count_q, count_d;
    logic [2*DATA_W-1:0] mdata_q, mdata_d;
    logic                mvalid_q, mvalid_d;
    logic                idle_q, idle_d;

    logic                full, empty, push, pop, out_free;
    logic [DATA_W-1:0]   head;
    logic [2*DATA_W-1:0] head_enc;

    assign full       = (count_q == LVL_W'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    // No look-ahead on a same-cycle pop: keeps data_ready off the serializer_ready path.
    assign data_ready = !full && !flush;
    assign push       = data_valid && data_ready;
    assign out_free   = !mvalid_q || serializer_ready;
    assign pop        = out_free && !empty && !flush;
    assign head       = mem_q[rd_ptr_q];

    // Per-bit symbol: polarity 0 gives {~b, b}, polarity 1 gives {b, ~b}.
    for (genvar i = 0; i < DATA_W; i++) begin : g_lane
        assign head_enc[2*i+1] = head[i] ^ ~polarity;
        assign head_enc[2*i]   = head[i] ^ polarity;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + LVL_W'(1);
                2'b01:   count_d = count_q - LVL_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        mdata_d  = mdata_q;
        mvalid_d = mvalid_q;
        idle_d   = idle_q;
        if (flush) begin
            mvalid_d = 1'b0;
            idle_d   = 1'b0;
        end else if (pop) begin
            mdata_d  = head_enc;
            mvalid_d = 1'b1;
            idle_d   = 1'b0;
        end else if (out_free) begin
`ifdef SERDESPHY_MENC_IDLE_FILL_EN
            mdata_d  = {DATA_W{{~polarity, polarity}}};
            mvalid_d = 1'b1;
            idle_d   = 1'b1;
`else
            mvalid_d = 1'b0;
            idle_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mdata_q  <= '0;
            mvalid_q <= 1'b0;
            idle_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mdata_q  <= mdata_d;
            mvalid_q <= mvalid_d;
            idle_q   <= idle_d;
        end
    end

    assign manchester_data  = mdata_q;
    assign manchester_valid = mvalid_q;
    assign fifo_level       = count_q;
    assign idle_flag        = idle_q;
endmodule

// File: tb/tb_serdesphy_manchester_encoder_pipe.sv
// Directed-vector bench for serdesphy_manchester_encoder_pipe (DATA_W=8, FIFO_DEPTH=4).
module tb_serdesphy_manchester_encoder_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic        polarity;
    logic        flush;
    logic [15:0] manchester_data;
    logic        manchester_valid;
    logic        serializer_ready;
    logic [2:0]  fifo_level;
    logic        idle_flag;

    int checks = 0;
    int errors = 0;

    serdesphy_manchester_encoder_pipe #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .polarity(polarity), .flush(flush),
        .manchester_data(manchester_data), .manchester_valid(manchester_valid),
        .serializer_ready(serializer_ready), .fifo_level(fifo_level), .idle_flag(idle_flag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data_in = '0; data_valid = 1'b0; polarity = 1'b0;
        flush = 1'b0; serializer_ready = 1'b1;
        #12;
        checks++;
        if (manchester_valid !== 1'b0 || manchester_data !== 16'h0000 || fifo_level !== 3'd0 || idle_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h lvl=%0d idle=%b exp v=0 d=0000 lvl=0 idle=0",
                     manchester_valid, manchester_data, fifo_level, idle_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", data_ready);
        end
    endtask

    task automatic test_back_to_back();
        step();
        polarity = 1'b0; serializer_ready = 1'b1;
        data_in = 8'h00; data_valid = 1'b1;
        step();
        checks++;
        if (manchester_valid !== 1'b0 || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL b2b_latency got v=%b lvl=%0d exp v=0 lvl=1", manchester_valid, fifo_level);
        end
        data_in = 8'hFF;
        step();
        checks++;
        if (manchester_valid !== 1'b1 || manchester_data !== 16'hAAAA) begin
            errors++;
            $display("FAIL b2b_w0 got v=%b d=%h exp v=1 d=aaaa", manchester_valid, manchester_data);
        end
        data_in = 8'hA5;
        step();
        checks++;
        if (manchester_valid !== 1'b1 || manchester_data !== 16'h5555) begin
            errors++;
            $display("FAIL b2b_w1 got v=%b d=%h exp v=1 d=5555", manchester_valid, manchester_data);
        end
        data_valid = 1'b0;
        step();
        checks++;
        if (manchester_valid !== 1'b1 || manchester_data !== 16'h6699) begin
            errors++;
            $display("FAIL b2b_w2 got v=%b d=%h exp v=1 d=6699", manchester_valid, manchester_data);
        end
        step();
        checks++;
        if (manchester_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL b2b_drain got v=%b lvl=%0d exp v=0 lvl=0", manchester_valid, fifo_level);
        end
    endtask

    task automatic test_polarity();
        polarity = 1'b1; data_in = 8'hA5; data_valid = 1'b1;
        step();
        data_valid = 1'b0; serializer_ready = 1'b0;
        step();
        checks++;
        if (manchester_valid !== 1'b1 || manchester_data !== 16'h9966) begin
            errors++;
            $display("FAIL pol1_enc got v=%b d=%h exp v=1 d=9966", manchester_valid, manchester_data);
        end
        polarity = 1'b0;
        step();
        step();
        checks++;
        if (manchester_valid !== 1'b1 || manchester_data !== 16'h9966) begin
            errors++;
            $display("FAIL pol_hold got v=%b d=%h exp v=1 d=9966", manchester_valid, manchester_data);
        end
        serializer_ready = 1'b1;
        step();
        checks++;
        if (manchester_valid !== 1'b0) begin
            errors++;
            $display("FAIL pol_consume got v=%b exp 0", manchester_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        serializer_ready = 1'b0; polarity = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in = words[i]; data_valid = 1'b1;
            step();
        end
        checks++;
        if (fifo_level !== 3'd4 || data_ready !== 1'b0 || manchester_data !== 16'hA9A9 || manchester_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full got lvl=%0d rdy=%b v=%b d=%h exp lvl=4 rdy=0 v=1 d=a9a9",
                     fifo_level, data_ready, manchester_valid, manchester_data);
        end
        data_in = 8'h66;
        step();
        checks++;
        if (fifo_level !== 3'd4 || manchester_data !== 16'hA9A9) begin
            errors++;
            $display("FAIL bp_reject got lvl=%0d d=%h exp lvl=4 d=a9a9", fifo_level, manchester_data);
        end
    endtask

    task automatic test_full_pop();
        logic [15:0] exp_out [3] = '{16'hA5A5, 16'h9A9A, 16'h9999};
        data_in = 8'h66; data_valid = 1'b1; serializer_ready = 1'b1;
        #1;
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_ready got %b exp 0", data_ready);
        end
        step();
        checks++;
        if (fifo_level !== 3'd3 || manchester_data !== 16'hA6A6 || data_ready !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_level got lvl=%0d d=%h rdy=%b exp lvl=3 d=a6a6 rdy=1",
                     fifo_level, manchester_data, data_ready);
        end
        data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (manchester_valid !== 1'b1 || manchester_data !== exp_out[i]) begin
                errors++;
                $display("FAIL drain_order[%0d] got v=%b d=%h exp v=1 d=%h", i, manchester_valid, manchester_data, exp_out[i]);
            end
        end
        step();
        checks++;
        if (manchester_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL drain_end got v=%b lvl=%0d exp v=0 lvl=0", manchester_valid, fifo_level);
        end
    endtask

    task automatic test_flush_reset();
        serializer_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'h11 * 8'(i + 1); data_valid = 1'b1;
            step();
        end
        checks++;
        if (fifo_level !== 3'd3 || manchester_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got lvl=%0d v=%b exp lvl=3 v=1", fifo_level, manchester_valid);
        end
        data_in = 8'h77; flush = 1'b1;
        #1;
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %b exp 0", data_ready);
        end
        step();
        checks++;
        if (fifo_level !== 3'd0 || manchester_valid !== 1'b0 || idle_flag !== 1'b0 || manchester_data !== 16'hA9A9) begin
            errors++;
            $display("FAIL flush_clear got lvl=%0d v=%b idle=%b d=%h exp lvl=0 v=0 idle=0 d=a9a9",
                     fifo_level, manchester_valid, idle_flag, manchester_data);
        end
        flush = 1'b0; data_valid = 1'b0; serializer_ready = 1'b1;
        step();
        step();
        checks++;
        if (manchester_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL flush_drop got v=%b lvl=%0d exp v=0 lvl=0", manchester_valid, fifo_level);
        end
        serializer_ready = 1'b0; data_in = 8'h3C; data_valid = 1'b1;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (manchester_valid !== 1'b0 || manchester_data !== 16'h0000 || fifo_level !== 3'd0 || data_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%h lvl=%0d rdy=%b exp v=0 d=0000 lvl=0 rdy=1",
                     manchester_valid, manchester_data, fifo_level, data_ready);
        end
        data_valid = 1'b0; serializer_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_idle_fill();
        polarity = 1'b0; serializer_ready = 1'b1; data_valid = 1'b0;
        step();
`ifdef SERDESPHY_MENC_IDLE_FILL_EN
        checks++;
        if (manchester_valid !== 1'b1 || manchester_data !== 16'hAAAA || idle_flag !== 1'b1) begin
            errors++;
            $display("FAIL idle_word got v=%b d=%h idle=%b exp v=1 d=aaaa idle=1", manchester_valid, manchester_data, idle_flag);
        end
        data_in = 8'hFF; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step();
        checks++;
        if (manchester_valid !== 1'b1 || manchester_data !== 16'h5555 || idle_flag !== 1'b0) begin
            errors++;
            $display("FAIL idle_data got v=%b d=%h idle=%b exp v=1 d=5555 idle=0", manchester_valid, manchester_data, idle_flag);
        end
        step();
        checks++;
        if (manchester_valid !== 1'b1 || manchester_data !== 16'hAAAA || idle_flag !== 1'b1) begin
            errors++;
            $display("FAIL idle_return got v=%b d=%h idle=%b exp v=1 d=aaaa idle=1", manchester_valid, manchester_data, idle_flag);
        end
`else
        checks++;
        if (manchester_valid !== 1'b0 || idle_flag !== 1'b0) begin
            errors++;
            $display("FAIL no_idle got v=%b idle=%b exp v=0 idle=0", manchester_valid, idle_flag);
        end
`endif
    endtask

    initial begin
        test_reset();
`ifndef SERDESPHY_MENC_IDLE_FILL_EN
        test_back_to_back();
        test_polarity();
        test_backpressure();
        test_full_pop();
        test_flush_reset();
`endif
        test_idle_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
